// File: rtl/mips_decode_issue.sv
// Decode/issue stage: one-entry instruction buffer, RAW busy scoreboard, operand bundle to execute.
// Optional macro MIPS_DECODE_ILLEGAL_EN adds iss_illegal for unknown opcode/funct encodings.
module mips_decode_issue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] instr,
    output logic [REG_AW-1:0] read_reg_1,
    output logic [REG_AW-1:0] read_reg_2,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [5:0]        iss_opcode,
    output logic [5:0]        iss_funct,
    output logic [DATA_W-1:0] iss_op_a,
    output logic [DATA_W-1:0] iss_op_b,
    output logic [DATA_W-1:0] iss_imm,
    output logic [REG_AW-1:0] iss_dest,
    output logic              iss_reg_write,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_reg
`ifdef MIPS_DECODE_ILLEGAL_EN
    ,
    output logic              iss_illegal
`endif
);

    localparam int unsigned NREG  = 1 << REG_AW;
    localparam int unsigned OPC_W = 6;
    localparam int unsigned IMM_W = 16;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPC_W-1:0] FN_JR    = 6'h08;

    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;

    logic              r_iss_valid;
    logic [OPC_W-1:0]  r_iss_opcode;
    logic [OPC_W-1:0]  r_iss_funct;
    logic [DATA_W-1:0] r_iss_op_a;
    logic [DATA_W-1:0] r_iss_op_b;
    logic [DATA_W-1:0] r_iss_imm;
    logic [REG_AW-1:0] r_iss_dest;
    logic              r_iss_reg_write;

    logic [OPC_W-1:0]  w_opcode;
    logic [OPC_W-1:0]  w_funct;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [IMM_W-1:0]  w_imm16;
    logic [DATA_W-1:0] w_imm;
    logic [REG_AW-1:0] w_dest;
    logic              w_reads_rs;
    logic              w_reads_rt;
    logic              w_rw;
    logic              w_reg_write;
    logic              w_hazard;
    logic              w_advance;
    logic              w_accept;

    assign w_opcode = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_imm16  = r_ir[15:0];

    // Logical immediates are zero-extended; everything else sign-extends.
    assign w_imm = (w_opcode == OP_ANDI || w_opcode == OP_ORI || w_opcode == OP_XORI)
                 ? {{(DATA_W-IMM_W){1'b0}}, w_imm16}
                 : {{(DATA_W-IMM_W){w_imm16[IMM_W-1]}}, w_imm16};

    always_comb begin
        w_reads_rs = 1'b0;
        w_reads_rt = 1'b0;
        w_rw       = 1'b0;
        w_dest     = '0;
        unique case (w_opcode)
            OP_RTYPE: begin
                w_dest     = w_rd;
                w_reads_rs = 1'b1;
                if (w_funct != FN_JR) begin
                    w_reads_rt = 1'b1;
                    w_rw       = 1'b1;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, OP_ANDI, OP_ORI, OP_XORI, 6'h0F, OP_LW: begin
                w_dest     = w_rt;
                w_reads_rs = 1'b1;
                w_rw       = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                w_reads_rs = 1'b1;
                w_reads_rt = 1'b1;
            end
            OP_JAL: begin
                w_dest = REG_AW'(31);
                w_rw   = 1'b1;
            end
            default: begin
                w_rw = 1'b0;
            end
        endcase
    end

`ifdef MIPS_DECODE_ILLEGAL_EN
    logic w_illegal;
    logic r_iss_illegal;

    always_comb begin
        w_illegal = 1'b0;
        if (w_opcode == OP_RTYPE) begin
            w_illegal = !(w_funct inside {6'h00, 6'h02, 6'h03, 6'h08, [6'h20:6'h27], 6'h2A, 6'h2B});
        end else if (!(w_opcode inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, [6'h08:6'h0F], OP_LW, OP_SW})) begin
            w_illegal = 1'b1;
        end
    end

    // Illegal bundles never claim a destination, so the scoreboard is untouched.
    assign w_reg_write = w_rw && (w_dest != '0) && !w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_illegal <= 1'b0;
        end else if (w_advance) begin
            r_iss_illegal <= w_illegal;
        end
    end

    assign iss_illegal = r_iss_illegal;
`else
    assign w_reg_write = w_rw && (w_dest != '0);
`endif

    // Registered busy only: a writeback landing this edge is visible next cycle.
    assign w_hazard  = r_ir_valid &&
                       ((w_reads_rs && (w_rs != '0) && r_busy[w_rs]) ||
                        (w_reads_rt && (w_rt != '0) && r_busy[w_rt]));
    assign w_advance = r_ir_valid && !w_hazard && (!r_iss_valid || iss_ready);
    assign w_accept  = instr_valid && instr_ready;

    assign instr_ready = !r_ir_valid || w_advance;
    assign read_reg_1  = w_rs;
    assign read_reg_2  = w_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_accept) begin
            r_ir       <= instr;
            r_ir_valid <= 1'b1;
        end else if (w_advance) begin
            r_ir_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid     <= 1'b0;
            r_iss_opcode    <= '0;
            r_iss_funct     <= '0;
            r_iss_op_a      <= '0;
            r_iss_op_b      <= '0;
            r_iss_imm       <= '0;
            r_iss_dest      <= '0;
            r_iss_reg_write <= 1'b0;
        end else if (w_advance) begin
            r_iss_valid     <= 1'b1;
            r_iss_opcode    <= w_opcode;
            r_iss_funct     <= w_funct;
            r_iss_op_a      <= read_data_1;
            r_iss_op_b      <= read_data_2;
            r_iss_imm       <= w_imm;
            r_iss_dest      <= w_dest;
            r_iss_reg_write <= w_reg_write;
        end else if (iss_ready) begin
            r_iss_valid <= 1'b0;
        end
    end

    // Clear on writeback, then set on issue so a same-register collision stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) begin
            w_busy_nxt[wb_reg] = 1'b0;
        end
        if (w_advance && w_reg_write) begin
            w_busy_nxt[w_dest] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign iss_valid     = r_iss_valid;
    assign iss_opcode    = r_iss_opcode;
    assign iss_funct     = r_iss_funct;
    assign iss_op_a      = r_iss_op_a;
    assign iss_op_b      = r_iss_op_b;
    assign iss_imm       = r_iss_imm;
    assign iss_dest      = r_iss_dest;
    assign iss_reg_write = r_iss_reg_write;

endmodule
